// File: rtl/addsub_pkg.sv
// addsub_pkg
//   Shared definitions for the pipelined adder/subtractor slice.
//   OP_ADD / OP_SUB : encoding of the in_op operation select.
//   stage_ctl_t     : control part of one pipeline stage record (valid, op, carry).
//   The operand and sum words of the record are WIDTH-dependent, so they live in addsub_pipe.
//   seg_w()         : width of one carry segment for a given WIDTH/STAGES split.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic valid;
    logic op;
    logic carry;
  } stage_ctl_t;

  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_if.sv
// addsub_if
//   Handshake bundle for addsub_pipe.
//   Input side : in_valid, in_ready, in_a, in_b, in_op
//   Output side: out_valid, out_ready, out_res, out_neg, out_cout
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : arithmetic unit side (drives in_ready and the result)
interface addsub_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_neg;
  logic             out_cout;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_res, out_neg, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_res, out_neg, out_cout
  );

endinterface

// File: rtl/addsub_seg.sv
// addsub_seg
//   Combinational SEG_W-bit ripple-carry adder built from per-bit full adders.
//   Ports: a, b (SEG_W) operands; cin carry in; sum (SEG_W); cout carry out of the top bit.
module addsub_seg
  import addsub_pkg::*;
#(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  logic [SEG_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SEG_W];

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe
//   Pipelined unsigned WIDTH-bit adder/subtractor with valid/ready handshake.
//   The carry chain is cut into STAGES registered segments, followed by one
//   correction stage that turns a negative subtraction into magnitude + sign.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : addsub_if.slave (in_valid/in_ready/in_a/in_b/in_op,
//             out_valid/out_ready/out_res/out_neg/out_cout)
//   Build option ADDSUB_SAT_EN: when defined, an add that carries out
//   saturates out_res to all ones; otherwise the sum wraps.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  addsub_if.slave bus
);

  localparam int SEG_W = seg_w(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] bx_first;

  // acc holds finished sum bits below the current segment and untouched a bits above it;
  // bx holds b (already inverted for subtract) shifted so the next segment sits at bit 0.
  stage_ctl_t       ctl_q   [STAGES];
  logic [WIDTH-1:0] acc_q   [STAGES];
  logic [WIDTH-1:0] bx_q    [STAGES];
  stage_ctl_t       ctl_nxt [STAGES];
  logic [WIDTH-1:0] acc_nxt [STAGES];
  logic [WIDTH-1:0] bx_nxt  [STAGES];

  logic             out_valid_q;
  logic [WIDTH-1:0] out_res_q;
  logic             out_neg_q;
  logic             out_cout_q;

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] fix_a;
  logic [WIDTH-1:0] fixed;
  logic [WIDTH-1:0] res_c;
  logic             fix;
  logic             fix_cout_unused;

  // A full output register that is not being taken freezes the whole pipe.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign accept       = bus.in_valid & ~stall;
  assign bus.in_ready = ~stall;
  assign bx_first     = bus.in_b ^ {WIDTH{bus.in_op == OP_SUB}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic             op_in;
    logic             c_in;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] bx_in;
    logic [SEG_W-1:0] seg_sum;
    logic             seg_cout;
    logic [WIDTH-1:0] acc_upd;

    if (k == 0) begin : g_first
      assign v_in   = accept;
      assign op_in  = bus.in_op;
      assign c_in   = (bus.in_op == OP_SUB);
      assign acc_in = bus.in_a;
      assign bx_in  = bx_first;
    end else begin : g_next
      assign v_in   = ctl_q[k-1].valid;
      assign op_in  = ctl_q[k-1].op;
      assign c_in   = ctl_q[k-1].carry;
      assign acc_in = acc_q[k-1];
      assign bx_in  = bx_q[k-1];
    end

    addsub_seg #(.SEG_W(SEG_W)) u_seg (
      .a    (acc_in[k*SEG_W +: SEG_W]),
      .b    (bx_in[SEG_W-1:0]),
      .cin  (c_in),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    // Splice this segment's sum into the word in place of the a bits it consumed.
    always_comb begin
      acc_upd                     = acc_in;
      acc_upd[k*SEG_W +: SEG_W]   = seg_sum;
    end

    assign ctl_nxt[k] = '{valid: v_in, op: op_in, carry: seg_cout};
    assign acc_nxt[k] = acc_upd;
    assign bx_nxt[k]  = bx_in >> SEG_W;
  end

  // Segment registers: valid always advances so bubbles flow through, data only on a real beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        acc_q[k] <= '0;
        bx_q[k]  <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k].valid <= ctl_nxt[k].valid;
        if (ctl_nxt[k].valid) begin
          ctl_q[k].op    <= ctl_nxt[k].op;
          ctl_q[k].carry <= ctl_nxt[k].carry;
          acc_q[k]       <= acc_nxt[k];
          bx_q[k]        <= bx_nxt[k];
        end
      end
    end
  end

  // No carry out of a subtraction means a<b: the raw word is 2's-complement negative.
  assign raw   = acc_q[LAST];
  assign fix   = (ctl_q[LAST].op == OP_SUB) & ~ctl_q[LAST].carry;
  assign fix_a = fix ? ~raw : raw;

  addsub_seg #(.SEG_W(WIDTH)) u_fix (
    .a    (fix_a),
    .b    ('0),
    .cin  (fix),
    .sum  (fixed),
    .cout (fix_cout_unused)
  );

  always_comb begin
    res_c = fixed;
`ifdef ADDSUB_SAT_EN
    if ((ctl_q[LAST].op == OP_ADD) && ctl_q[LAST].carry) begin
      res_c = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_neg_q   <= 1'b0;
      out_cout_q  <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= ctl_q[LAST].valid;
      if (ctl_q[LAST].valid) begin
        out_res_q  <= res_c;
        out_neg_q  <= fix;
        out_cout_q <= ctl_q[LAST].carry;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_neg   = out_neg_q;
  assign bus.out_cout  = out_cout_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe
//   Self-checking bench for addsub_pipe (WIDTH=8, STAGES=2, latency 3).
//   Drives the addsub_if master side; a monitor collects every accepted result
//   and compares it against hand-computed vectors or an arithmetic reference.
//   Honours ADDSUB_SAT_EN for the expected saturating add results.
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int WIDTH   = 8;
  localparam int STAGES  = 2;
  localparam int LATENCY = STAGES + 1;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       neg;
    logic       cout;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       neg;
    logic       cout;
    int         cyc;
  } beat_t;

  logic  clk     = 1'b0;
  logic  rst_n   = 1'b0;
  int    cyc     = 0;
  int    nChecks = 0;
  int    nFail   = 0;
  beat_t expQ[$];
  beat_t gotQ[$];

  addsub_if #(.WIDTH(WIDTH)) bus ();

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each result that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      gotQ.push_back('{bus.out_res, bus.out_neg, bus.out_cout, cyc});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t refModel(input logic op, input logic [7:0] a, input logic [7:0] b);
    vec_t       v;
    logic [8:0] s;
    v.op = op;
    v.a  = a;
    v.b  = b;
    if (op == OP_ADD) begin
      s      = {1'b0, a} + {1'b0, b};
      v.res  = (SAT_EN && s[8]) ? 8'hFF : s[7:0];
      v.neg  = 1'b0;
      v.cout = s[8];
    end else if (a >= b) begin
      v.res  = a - b;
      v.neg  = 1'b0;
      v.cout = 1'b1;
    end else begin
      v.res  = b - a;
      v.neg  = 1'b1;
      v.cout = 1'b0;
    end
    return v;
  endfunction

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic applyStimulus(input vec_t v);
    int waited;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = v.op;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) checkOutput("in_ready wait", int'(bus.in_ready), 1);
    expQ.push_back('{v.res, v.neg, v.cout, cyc});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drainAndCheck(input string tag, input bit checkLat);
    beat_t e;
    beat_t g;
    int    i;
    i = 0;
    while (gotQ.size() < expQ.size() && i < 100) begin
      @(negedge clk);
      i++;
    end
    repeat (4) @(negedge clk);
    checkOutput({tag, " count"}, gotQ.size(), expQ.size());
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front();
      g = gotQ.pop_front();
      checkOutput({tag, " res"}, int'(g.res), int'(e.res));
      checkOutput({tag, " neg"}, int'(g.neg), int'(e.neg));
      checkOutput({tag, " cout"}, int'(g.cout), int'(e.cout));
      if (checkLat) checkOutput({tag, " latency"}, g.cyc - e.cyc, LATENCY);
    end
    expQ.delete();
    gotQ.delete();
  endtask

  initial begin
    vec_t       vecs [13];
    logic       rop;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0]  = '{OP_ADD, 8'd200, 8'd100, SAT_EN ? 8'd255 : 8'd44,  1'b0, 1'b1};
    vecs[1]  = '{OP_SUB, 8'd5,   8'd9,   8'd4,   1'b1, 1'b0};
    vecs[2]  = '{OP_SUB, 8'd9,   8'd5,   8'd4,   1'b0, 1'b1};
    vecs[3]  = '{OP_SUB, 8'd0,   8'd255, 8'd255, 1'b1, 1'b0};
    vecs[4]  = '{OP_SUB, 8'd77,  8'd77,  8'd0,   1'b0, 1'b1};
    vecs[5]  = '{OP_SUB, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1};
    vecs[6]  = '{OP_ADD, 8'd255, 8'd255, SAT_EN ? 8'd255 : 8'd254, 1'b0, 1'b1};
    vecs[7]  = '{OP_ADD, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
    vecs[8]  = '{OP_ADD, 8'd18,  8'd52,  8'd70,  1'b0, 1'b0};
    vecs[9]  = '{OP_ADD, 8'd15,  8'd1,   8'd16,  1'b0, 1'b0};
    vecs[10] = '{OP_SUB, 8'd16,  8'd1,   8'd15,  1'b0, 1'b1};
    vecs[11] = '{OP_SUB, 8'd1,   8'd16,  8'd15,  1'b1, 1'b0};
    vecs[12] = '{OP_ADD, 8'd128, 8'd128, SAT_EN ? 8'd255 : 8'd0,   1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_op     = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", int'(bus.out_valid), 0);
    checkOutput("reset out_res", int'(bus.out_res), 0);
    checkOutput("reset out_neg", int'(bus.out_neg), 0);
    checkOutput("reset out_cout", int'(bus.out_cout), 0);
    checkOutput("reset in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      drainAndCheck($sformatf("vec%0d", i), 1'b1);
      @(posedge clk);
      #1;
    end

    $display("[TB] back-to-back stream");
    for (int i = 0; i < 8; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      applyStimulus(refModel(rop, ra, rb));
    end
    drainAndCheck("stream", 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] back-pressure");
    bus.out_ready = 1'b0;
    fork
      begin
        applyStimulus('{OP_ADD, 8'd10,  8'd20,  8'd30,  1'b0, 1'b0});
        applyStimulus('{OP_SUB, 8'd100, 8'd1,   8'd99,  1'b0, 1'b1});
        applyStimulus('{OP_SUB, 8'd3,   8'd200, 8'd197, 1'b1, 1'b0});
        applyStimulus('{OP_ADD, 8'd250, 8'd10,  SAT_EN ? 8'd255 : 8'd4, 1'b0, 1'b1});
        applyStimulus('{OP_ADD, 8'd1,   8'd1,   8'd2,   1'b0, 1'b0});
      end
      begin
        repeat (5) @(negedge clk);
        checkOutput("stall in_ready", int'(bus.in_ready), 0);
        checkOutput("stall out_valid", int'(bus.out_valid), 1);
        checkOutput("stall out_res", int'(bus.out_res), 30);
        @(negedge clk);
        checkOutput("stall out_res held", int'(bus.out_res), 30);
        checkOutput("stall in_ready held", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drainAndCheck("stall", 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] reset with beats in flight");
    applyStimulus('{OP_ADD, 8'd200, 8'd100, SAT_EN ? 8'd255 : 8'd44, 1'b0, 1'b1});
    applyStimulus('{OP_ADD, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0});
    applyStimulus('{OP_SUB, 8'd9, 8'd5, 8'd4, 1'b0, 1'b1});
    checkOutput("pre-reset out_valid", int'(bus.out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", int'(bus.out_valid), 0);
    checkOutput("mid-reset out_res", int'(bus.out_res), 0);
    checkOutput("mid-reset out_cout", int'(bus.out_cout), 0);
    checkOutput("mid-reset in_ready", int'(bus.in_ready), 1);
    expQ.delete();
    gotQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("ghost beats", gotQ.size(), 0);
    checkOutput("post-reset out_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    applyStimulus('{OP_ADD, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0});
    drainAndCheck("post-reset", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
